// File: rtl/and_slice_sequencer.sv
// Multi-cycle front end for an external SLICE-bit AND unit: issues one operand slice per
// cycle (LSB first), gathers the returned slices and presents the result under valid/ready.
module and_slice_sequencer #(
  parameter  int WIDTH = 32,
  parameter  int SLICE = 8,
  localparam int NSL   = WIDTH / SLICE,
  localparam int IW    = (NSL > 1) ? $clog2(NSL) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [SLICE-1:0] sl_x,
  output logic [SLICE-1:0] sl_y,
  input  logic [SLICE-1:0] sl_s,
  output logic [IW-1:0]    sl_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_zero
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready and out_valid are decoded from the state register only, so neither side
  // sees a combinational path from the other.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_next;
  logic [IW-1:0]    idx;
  logic             zero_q;

  // Result with the current returned slice merged in; also feeds the zero flag.
  always_comb begin
    s_next = s_q;
    s_next[int'(idx)*SLICE +: SLICE] = sl_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      zero_q <= 1'b1;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q    <= in_x;
            y_q    <= in_y;
            s_q    <= '0;
            zero_q <= 1'b1;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          s_q <= s_next;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            zero_q <= (s_next == '0);
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_s     = s_q;
  assign out_zero  = zero_q;
  assign sl_idx    = (state == RUN) ? idx : '0;
  assign sl_x      = (state == RUN) ? x_q[int'(idx)*SLICE +: SLICE] : '0;
  assign sl_y      = (state == RUN) ? y_q[int'(idx)*SLICE +: SLICE] : '0;

endmodule

// File: tb/tb_and_slice_sequencer.sv
// Bench for and_slice_sequencer: behavioural AND unit on the slice port, scoreboard of
// X&Y results pushed on input acceptance and popped on the output handshake.
module tb_and_slice_sequencer;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [SLICE-1:0] sl_x;
  logic [SLICE-1:0] sl_y;
  logic [SLICE-1:0] sl_s;
  logic [1:0]       sl_idx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_zero;

  and_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .sl_x(sl_x), .sl_y(sl_y), .sl_s(sl_s), .sl_idx(sl_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_zero(out_zero)
  );

  // External AND unit
  assign sl_s = sl_x & sl_y;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [WIDTH:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -100;
  int last_hs = -100;
  int n_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: handshakes are judged on the values held since #1 after the previous edge.
  task automatic tick();
    logic             acc, hs, z;
    logic [WIDTH-1:0] x, y, s;
    logic [WIDTH:0]   e;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    x = in_x; y = in_y; s = out_s; z = out_zero;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_out_s", s, e[WIDTH-1:0]);
        check("sb_out_zero", z, e[WIDTH]);
      end
    end
    if (acc) begin
      exp_q.push_back({((x & y) == '0), (x & y)});
      last_acc = cyc;
      n_acc++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
  endtask

  logic [7:0] exp_x_b[4];
  logic [7:0] exp_y_b[4];

  initial begin
    logic [WIDTH-1:0] held;
    int acc0, prev_acc, target;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("por_out_valid", out_valid, 0);
    check("por_out_s", out_s, 0);
    check("por_out_zero", out_zero, 1);
    check("por_in_ready", in_ready, 1);
    check("por_sl_x", sl_x, 0);
    check("por_sl_idx", sl_idx, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // basic transaction with slice-by-slice checks
    exp_x_b = '{8'hA5, 8'hA5, 8'hF0, 8'hF0};
    exp_y_b = '{8'hF0, 8'h0F, 8'h00, 8'hFF};
    out_ready = 1'b1;
    drive(32'hF0F0_A5A5, 32'hFF00_0FF0);
    tick();
    in_valid = 1'b0;
    check("basic_accept", last_acc, cyc);
    check("basic_run_out_s_cleared", out_s, 0);
    for (int i = 0; i < 4; i++) begin
      check("basic_sl_idx", sl_idx, i);
      check("basic_sl_x", sl_x, exp_x_b[i]);
      check("basic_sl_y", sl_y, exp_y_b[i]);
      check("basic_in_ready_run", in_ready, 0);
      check("basic_out_valid_run", out_valid, 0);
      tick();
    end
    check("basic_out_valid", out_valid, 1);
    check("basic_out_s", out_s, 32'hF000_05A0);
    check("basic_out_zero", out_zero, 0);
    check("basic_latency", cyc + 1 - last_acc, 5);
    tick();
    check("basic_post_out_valid", out_valid, 0);
    check("basic_post_in_ready", in_ready, 1);
    check("basic_post_out_s_held", out_s, 32'hF000_05A0);
    check("basic_idle_sl_x", sl_x, 0);

    // mid-cycle reset while holding a nonzero result in DONE
    out_ready = 1'b0;
    drive(32'hFFFF_0000, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    wait_out_valid("rst_reach_done");
    #3;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_in_ready", in_ready, 1);
    exp_q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    out_ready = 1'b1;

    // zero result
    drive(32'h1234_5678, 32'hEDCB_A987);
    tick();
    in_valid = 1'b0;
    wait_out_valid("zero_reach_done");
    check("zero_out_s", out_s, 0);
    check("zero_out_zero", out_zero, 1);
    drain();

    // backpressure
    out_ready = 1'b0;
    acc0 = n_acc;
    drive(32'hDEAD_BEEF, 32'h0F0F_F0F0);
    tick();
    wait_out_valid("bp_reach_done");
    check("bp_out_s", out_s, 32'h0E0D_B0E0);
    held = out_s;
    for (int i = 0; i < 10; i++) begin
      in_x = $urandom;
      in_y = $urandom;
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_s_held", out_s, held);
    end
    check("bp_single_accept", n_acc - acc0, 1);
    out_ready = 1'b1;
    drive(32'h8000_0001, 32'h8000_0003);
    tick();
    check("bp_handshake", last_hs, cyc);
    check("bp_idle_in_ready", in_ready, 1);
    tick();
    check("bp_accept_gap", last_acc - last_hs, 1);
    in_valid = 1'b0;
    drain();

    // abort by reset during slice 2
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_sl_idx", sl_idx, 2);
    #3;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_s", out_s, 0);
    check("abort_in_ready", in_ready, 1);
    exp_q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 6; i++) begin
      check("abort_no_out_valid", out_valid, 0);
      tick();
    end
    drive(32'h0000_0001, 32'h0000_0003);
    tick();
    in_valid = 1'b0;
    wait_out_valid("abort_next_done");
    check("abort_next_out_s", out_s, 1);
    drain();

    // back-to-back, randomized operands changing every cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    target = n_acc + 8;
    prev_acc = -1;
    for (int n = 0; n < 200 && n_acc < target; n++) begin
      case ($urandom_range(0, 5))
        0: begin in_x = $urandom; in_y = ~in_x; end
        1: begin in_x = '1; in_y = $urandom; end
        default: begin in_x = $urandom; in_y = $urandom; end
      endcase
      tick();
      if (last_acc == cyc) begin
        if (prev_acc >= 0) check("b2b_gap", cyc - prev_acc, 6);
        prev_acc = cyc;
      end
    end
    check("b2b_accept_count", n_acc, target);
    in_valid = 1'b0;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
